// File: rtl/muldiv_if.sv
// Issue/result bundle between EXE and the mult/div sequencer.
// The pipeline side drives requests; the sequencer owns HI/LO.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [1:0]  mt_we;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, flush, mt_we, mt_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, mt_we, mt_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer and HI/LO owner.
// One shared 34-bit adder serves both shift-add and restoring divide.
module muldiv_ctrl #(
    parameter int STEPS = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic        is_div, sign_a, sign_b, b_zero;
    logic [31:0] a_raw, opnd, acc_hi, acc_lo;
    logic [31:0] hi_q, lo_q;
    logic        done_q, dz_q;

    logic        accept, mt_ok, step, wb;
    logic        signed_op, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    logic [33:0] add_a, add_b, sum;
    logic [32:0] mul_s;
    logic [31:0] hi_n, lo_n;
    logic [63:0] prod, prod_fix;
    logic [31:0] res_hi, res_lo;

    assign accept = (state == IDLE) && bus.start && !bus.flush;
    assign mt_ok  = (state == IDLE) && !bus.start;
    // The extra RUN cycle at cnt == STEPS is idle, so SIGN ends at E0+34.
    assign step   = (state == RUN) && (cnt != 6'(STEPS));
    assign wb     = (state == SIGN) && !bus.flush;

    // Signed ops work on magnitudes; -0x80000000 wraps to itself.
    assign signed_op = ~bus.op[0];
    assign neg_a = signed_op & bus.src_a[31];
    assign neg_b = signed_op & bus.src_b[31];
    assign mag_a = neg_a ? -bus.src_a : bus.src_a;
    assign mag_b = neg_b ? -bus.src_b : bus.src_b;

    // Shared adder: add multiplicand, or subtract divisor from shifted rem.
    always_comb begin
        add_a = is_div ? {1'b0, acc_hi, acc_lo[31]} : {2'b00, acc_hi};
        add_b = is_div ? ~{2'b00, opnd} : {2'b00, opnd};
        sum   = add_a + add_b + {33'd0, is_div};
    end

    // One iteration of either algorithm from the adder result.
    always_comb begin
        mul_s = acc_lo[0] ? sum[32:0] : {1'b0, acc_hi};
        if (is_div) begin
            hi_n = sum[33] ? {acc_hi[30:0], acc_lo[31]} : sum[31:0];
            lo_n = {acc_lo[30:0], ~sum[33]};
        end else begin
            hi_n = mul_s[32:1];
            lo_n = {mul_s[0], acc_lo[31:1]};
        end
    end

    // Sign fix-up and divide-by-zero result for writeback.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        res_hi   = prod_fix[63:32];
        res_lo   = prod_fix[31:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = 32'hffff_ffff;
            end else begin
                res_hi = sign_a ? -acc_hi : acc_hi;
                res_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush aborts from RUN or SIGN.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN: begin
                if (bus.flush)                state_nx = IDLE;
                else if (cnt == 6'(STEPS))    state_nx = SIGN;
            end
            SIGN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration datapath, HI/LO and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= wb;
            if (accept) begin
                is_div <= bus.op[1];
                sign_a <= neg_a;
                sign_b <= neg_b;
                b_zero <= (bus.src_b == 32'd0);
                a_raw  <= bus.src_a;
                cnt    <= '0;
                dz_q   <= 1'b0;
                acc_hi <= '0;
                acc_lo <= bus.op[1] ? mag_a : mag_b;
                opnd   <= bus.op[1] ? mag_b : mag_a;
            end
            if (step) begin
                acc_hi <= hi_n;
                acc_lo <= lo_n;
                cnt    <= cnt + 6'd1;
            end
            if (wb) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
                dz_q <= is_div & b_zero;
            end else if (mt_ok) begin
                if (bus.mt_we[1]) hi_q <= bus.mt_data;
                if (bus.mt_we[0]) lo_q <= bus.mt_data;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO queued at issue,
// popped and compared when done pulses.
module tb_muldiv_ctrl;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv_ctrl #(.STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        res_t r;
        logic [63:0] p;
        r.dz = 1'b0;
        p = '0;
        case (o)
            2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b01: p = {32'd0, a} * {32'd0, b};
            default: p = '0;
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        if (o[1]) begin
            if (b == 32'd0) begin
                r.hi = a;
                r.lo = 32'hffff_ffff;
                r.dz = 1'b1;
            end else if (o == 2'b11) begin
                r.lo = a / b;
                r.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                r.lo = 32'h8000_0000;
                r.hi = 32'd0;
            end else begin
                r.lo = 32'($signed(a) / $signed(b));
                r.hi = 32'($signed(a) % $signed(b));
            end
        end
        return r;
    endfunction

    // mid: 0 none, 1 second start mid-run, 2 MTHI mid-run
    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int mid);
        int n;
        int cyc;
        res_t e;
        logic [31:0] h0;
        h0 = bus.hi;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        sb.push_back(model(o, a, b));
        @(negedge clk);
        bus.start = 1'b0;
        chk("dz_clr", 64'(bus.div_zero), 64'd0);
        n = 0;
        cyc = 0;
        while (!bus.done && cyc < 200) begin
            cyc++;
            if (bus.busy) n++;
            if (cyc == 5) chk("no_fwd", 64'(bus.hi), 64'(h0));
            if (cyc == 10 && mid == 1) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.src_a = 32'd2;
                bus.src_b = 32'd2;
            end
            if (cyc == 10 && mid == 2) begin
                bus.mt_we   = 2'b10;
                bus.mt_data = 32'hdead_beef;
            end
            if (cyc == 11) begin
                bus.start = 1'b0;
                bus.mt_we = 2'b00;
            end
            @(negedge clk);
        end
        chk("done_seen", 64'(bus.done), 64'd1);
        chk("latency", 64'(n), 64'd34);
        chk("busy_end", 64'(bus.busy), 64'd0);
        chk("sb_size", 64'(sb.size()), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("hi", 64'(bus.hi), 64'(e.hi));
            chk("lo", 64'(bus.lo), 64'(e.lo));
            chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
        end
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.flush   = 1'b0;
        bus.mt_we   = 2'b00;
        bus.mt_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz", 64'(bus.div_zero), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;

        do_op(2'b00, 32'd7, 32'hffff_fffd, 0);
        do_op(2'b01, 32'hffff_ffff, 32'hffff_ffff, 1);
        do_op(2'b10, 32'hffff_fff9, 32'd2, 0);
        do_op(2'b10, 32'h8000_0000, 32'hffff_ffff, 0);
        do_op(2'b11, 32'd100, 32'd0, 0);
        do_op(2'b11, 32'd12345, 32'd7, 2);
        do_op(2'b10, 32'hffff_fffb, 32'd0, 0);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        for (int i = 0; i < 4; i++) begin
            do_op(2'($urandom_range(0, 3)), $urandom, $urandom, 0);
        end

        // preload, then flush an in-flight divide
        @(negedge clk);
        bus.mt_we   = 2'b11;
        bus.mt_data = 32'h1234_5678;
        @(negedge clk);
        bus.mt_we = 2'b00;
        chk("mt_hi", 64'(bus.hi), 64'h1234_5678);
        chk("mt_lo", 64'(bus.lo), 64'h1234_5678);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = 32'd9;
        bus.src_b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fl_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk("fl_done", 64'(bus.done), 64'd0);
            @(negedge clk);
        end
        chk("fl_hi", 64'(bus.hi), 64'h1234_5678);
        chk("fl_lo", 64'(bus.lo), 64'h1234_5678);
        do_op(2'b01, 32'd3, 32'd5, 0);

        // async reset mid-run
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd5;
        bus.src_b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_busy", 64'(bus.busy), 64'd0);
        chk("ar_done", 64'(bus.done), 64'd0);
        chk("ar_hi", 64'(bus.hi), 64'd0);
        chk("ar_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
